rf_wb_scheduler: RTL and testbench

- Controller for the pipeline's 32x8 register file: owns its single write port and shares it between two writeback requesters, ALU and MEM.
- Keeps a busy-register scoreboard and raises a stall to decode on RAW/WAW hazards.
- Sits between the decode/issue stage, the two writeback stages, and the register file write port (writeEnable/writeRpoint/writeData).
- The register file commits on negedge clk; this block drives its write port from posedge registers so values are stable at that negedge.

---
 rtl/rf_wb_scheduler.sv | 105 ++++++++++
 tb/tb_rf_wb_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_scheduler.sv
// Write-port owner for the 32x8 register file: busy-register scoreboard, RAW/WAW stall,
// and ALU/MEM writeback arbitration. Define RF_WB_ROUND_ROBIN_EN for alternating contested grants.
module rf_wb_scheduler #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_rs,
  input  logic [ADDR_W-1:0]         issue_rt,
  input  logic [ADDR_W-1:0]         issue_rd,
  input  logic                      issue_wr,
  output logic                      stall,
  input  logic                      alu_valid,
  input  logic [ADDR_W-1:0]         alu_rd,
  input  logic [DATA_W-1:0]         alu_data,
  output logic                      alu_ready,
  input  logic                      mem_valid,
  input  logic [ADDR_W-1:0]         mem_rd,
  input  logic [DATA_W-1:0]         mem_data,
  output logic                      mem_ready,
  output logic                      writeEnable,
  output logic [ADDR_W-1:0]         writeRpoint,
  output logic [DATA_W-1:0]         writeData,
  output logic [(1<<ADDR_W)-1:0]    busy_mask
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_next;
  logic              stall_raw;
  logic              issue_fire;
  logic              grant_mem;
  logic              grant_alu;
  logic              wb_fire;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  assign busy_mask = busy_q;

  // busy_q[0] is never set, so register 0 can never cause a stall
  always_comb begin
    stall_raw = issue_valid & (busy_q[issue_rs] | busy_q[issue_rt] |
                               (issue_wr & busy_q[issue_rd]));
  end

  assign stall      = ~rst & stall_raw;
  assign issue_fire = ~rst & issue_valid & ~stall_raw;

`ifdef RF_WB_ROUND_ROBIN_EN
  // rr_mem_next_q = 1 means MEM takes the next contested cycle
  logic rr_mem_next_q;

  assign grant_mem = mem_valid & (~alu_valid | rr_mem_next_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_mem_next_q <= 1'b0;
    end else if (alu_valid && mem_valid) begin
      rr_mem_next_q <= ~grant_mem;
    end
  end
`else
  assign grant_mem = mem_valid;
`endif

  assign grant_alu = alu_valid & ~grant_mem;
  assign mem_ready = ~rst & grant_mem;
  assign alu_ready = ~rst & grant_alu;
  assign wb_fire   = alu_ready | mem_ready;
  assign wb_rd     = grant_mem ? mem_rd   : alu_rd;
  assign wb_data   = grant_mem ? mem_data : alu_data;

  // Set applied after clear so an issue to the same register wins the edge
  always_comb begin
    busy_next = busy_q;
    if (wb_fire && (wb_rd != '0)) begin
      busy_next[wb_rd] = 1'b0;
    end
    if (issue_fire && issue_wr && (issue_rd != '0)) begin
      busy_next[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      writeEnable <= 1'b0;
      writeRpoint <= '0;
      writeData   <= '0;
    end else begin
      busy_q <= busy_next;
      if (wb_fire) begin
        writeEnable <= (wb_rd != '0);
        writeRpoint <= wb_rd;
        writeData   <= wb_data;
      end else begin
        writeEnable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed-vector bench for rf_wb_scheduler; expectations follow RF_WB_ROUND_ROBIN_EN if defined.
module tb_rf_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rs, issue_rt, issue_rd;
  logic        issue_wr;
  logic        stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [7:0]  alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [7:0]  mem_data;
  logic        mem_ready;
  logic        writeEnable;
  logic [4:0]  writeRpoint;
  logic [7:0]  writeData;
  logic [31:0] busy_mask;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_wb_scheduler dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_rd(issue_rd), .issue_wr(issue_wr), .stall(stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .writeEnable(writeEnable), .writeRpoint(writeRpoint), .writeData(writeData),
    .busy_mask(busy_mask)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rs = '0; issue_rt = '0; issue_rd = '0; issue_wr = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
  endtask

  logic first_mem;
  logic exp_mem;

  initial begin
    // reset with every requester active
    rst = 1'b1;
    issue_valid = 1'b1; issue_rs = 5'd1; issue_rt = 5'd2; issue_rd = 5'd5; issue_wr = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 8'h11;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 8'h22;
    step();
    step();
    mid();
    chk("rst_we", writeEnable, 0);
    chk("rst_wrp", writeRpoint, 0);
    chk("rst_wd", writeData, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_stall", stall, 0);
    chk("rst_alu_rdy", alu_ready, 0);
    chk("rst_mem_rdy", mem_ready, 0);
    rst = 1'b0;
    idle_inputs();
    step();

    // RAW: producer rd=5, consumer rs=5
    issue_valid = 1'b1; issue_rd = 5'd5; issue_wr = 1'b1;
    mid();
    chk("raw_issue_stall", stall, 0);
    step();
    chk("raw_busy5", busy_mask, 32'h20);
    issue_rs = 5'd5; issue_rd = 5'd6;
    mid();
    chk("raw_stall", stall, 1);
    step();
    chk("raw_busy_hold", busy_mask, 32'h20);
    chk("raw_we_idle", writeEnable, 0);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 8'h2A;
    mid();
    chk("raw_alu_rdy", alu_ready, 1);
    chk("raw_stall_wb", stall, 1);
    step();
    chk("raw_we", writeEnable, 1);
    chk("raw_wrp", writeRpoint, 5);
    chk("raw_wd", writeData, 8'h2A);
    chk("raw_busy_clr", busy_mask, 0);
    alu_valid = 1'b0;
    mid();
    chk("raw_stall_drop", stall, 0);
    step();
    chk("raw_busy6", busy_mask, 32'h40);
    chk("idle_we", writeEnable, 0);
    chk("idle_wrp_hold", writeRpoint, 5);
    chk("idle_wd_hold", writeData, 8'h2A);
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 8'h66;
    step();
    chk("wb6_busy", busy_mask, 0);
    chk("wb6_wrp", writeRpoint, 6);
    idle_inputs();

    // both requesters for four cycles with fresh data
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(8 + i);  alu_data = 8'(8'h30 + i);
      mem_valid = 1'b1; mem_rd = 5'(12 + i); mem_data = 8'(8'h40 + i);
`ifdef RF_WB_ROUND_ROBIN_EN
      exp_mem = (i % 2 == 1);
`else
      exp_mem = 1'b1;
`endif
      mid();
      chk("both_alu_rdy", alu_ready, !exp_mem);
      chk("both_mem_rdy", mem_ready, exp_mem);
      step();
      chk("both_wrp", writeRpoint, exp_mem ? 12 + i : 8 + i);
      chk("both_wd", writeData, exp_mem ? 8'h40 + i : 8'h30 + i);
    end
    idle_inputs();
    step();

    // contention alu(3,0x11) vs mem(4,0x22)
`ifdef RF_WB_ROUND_ROBIN_EN
    first_mem = 1'b0;
`else
    first_mem = 1'b1;
`endif
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 8'h11;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 8'h22;
    mid();
    chk("cont_mem_rdy", mem_ready, first_mem);
    chk("cont_alu_rdy", alu_ready, !first_mem);
    step();
    chk("cont_wrp1", writeRpoint, first_mem ? 4 : 3);
    chk("cont_wd1", writeData, first_mem ? 8'h22 : 8'h11);
    if (first_mem) mem_valid = 1'b0; else alu_valid = 1'b0;
    mid();
    chk("cont_loser_rdy", first_mem ? alu_ready : mem_ready, 1);
    step();
    chk("cont_wrp2", writeRpoint, first_mem ? 3 : 4);
    chk("cont_wd2", writeData, first_mem ? 8'h11 : 8'h22);
    chk("cont_we2", writeEnable, 1);
    idle_inputs();

    // register zero
    issue_valid = 1'b1; issue_rd = 5'd0; issue_wr = 1'b1;
    step();
    chk("r0_busy_issue", busy_mask, 0);
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 8'hFF;
    mid();
    chk("r0_alu_rdy", alu_ready, 1);
    step();
    chk("r0_we", writeEnable, 0);
    chk("r0_busy_wb", busy_mask, 0);
    chk("r0_wd", writeData, 8'hFF);
    idle_inputs();

    // issue and writeback to the same non-busy register on one edge
    issue_valid = 1'b1; issue_rd = 5'd9; issue_wr = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 8'h99;
    step();
    chk("setwin_busy", busy_mask, 32'h200);
    chk("setwin_we", writeEnable, 1);
    chk("setwin_wd", writeData, 8'h99);
    idle_inputs();

    // WAW on r7, then reset mid-operation
    issue_valid = 1'b1; issue_rd = 5'd7; issue_wr = 1'b1;
    step();
    chk("waw_busy", busy_mask, 32'h280);
    mid();
    chk("waw_stall", stall, 1);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 8'h77;
    rst = 1'b1;
    #1;
    chk("midrst_stall", stall, 0);
    chk("midrst_alu_rdy", alu_ready, 0);
    step();
    chk("midrst_busy", busy_mask, 0);
    chk("midrst_we", writeEnable, 0);
    alu_valid = 1'b0;
    rst = 1'b0;
    mid();
    chk("release_stall", stall, 0);
    step();
    chk("release_busy", busy_mask, 32'h80);
    chk("release_we", writeEnable, 0);
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
